// File: rtl/opt4c_column_result_collector_if.sv
// Beat/row bus between the OPT4C PE column array, the result collector and its consumer.
// Pure wiring, no latency.
// Beat side is valid/ready (in_ready), row side is valid/ready (out_ready).
interface opt4c_column_result_collector_if #(
  parameter int N            = 32,
  parameter int ACC_WIDTH    = 26,
  parameter int RESULT_WIDTH = 32,
  parameter int M            = 32
);
  localparam int ROW_W = $clog2(M);

  // Beat side: one bit-weight pass of all N columns, two lanes each
  logic [2*ACC_WIDTH*N-1:0]  pe_result;
  logic                      in_valid;
  logic [1:0]                in_bw;
  logic [ROW_W-1:0]          in_row;
  logic                      in_ready;

  // Row side: one finished row of N accumulated results
  logic [RESULT_WIDTH*N-1:0] out_data;
  logic [ROW_W-1:0]          out_row;
  logic                      out_valid;
  logic                      out_ready;

  // Sticky protocol error flag
  logic                      seq_err;

  // Producer of beats and consumer of rows (testbench / surrounding fabric)
  modport master (
    output pe_result, in_valid, in_bw, in_row, out_ready,
    input  in_ready, out_data, out_row, out_valid, seq_err
  );

  // The collector itself
  modport slave (
    input  pe_result, in_valid, in_bw, in_row, out_ready,
    output in_ready, out_data, out_row, out_valid, seq_err
  );
endinterface

// File: rtl/opt4c_column_result_collector.sv
// Fuses dual-lane PE column results, weights them by 4^bw and sums four passes into one output row.
// Latency: row registered on the edge accepting its bw=3 beat, visible the following cycle.
// Backpressure: in_ready = !out_valid || out_ready; a stalled output row freezes all beat intake.
module opt4c_column_result_collector #(
  parameter int N            = 32,
  parameter int ACC_WIDTH    = 26,
  parameter int RESULT_WIDTH = 32,
  parameter int M            = 32
) (
  input  logic clk,
  input  logic rst_n,
  opt4c_column_result_collector_if.slave bus
);

  localparam int ROW_W = $clog2(M);
  localparam int EXT_W = RESULT_WIDTH - ACC_WIDTH - 1;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t                    state;
  logic [1:0]                exp_bw;
  logic [ROW_W-1:0]          cur_row;
  logic [RESULT_WIDTH-1:0]   acc [N];

  logic [RESULT_WIDTH*N-1:0] out_data_q;
  logic [ROW_W-1:0]          out_row_q;
  logic                      out_valid_q;
  logic                      seq_err_q;

  logic [RESULT_WIDTH-1:0]   term [N];
  logic [RESULT_WIDTH-1:0]   sum  [N];
  logic [2:0]                shamt;

  logic                      in_ready;
  logic                      accept;
  logic                      hit;

  // Intake depends only on the output register, never on in_valid
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // A beat continues the open row only if it is the next pass of the same row
  assign hit = (state == ACC) && (bus.in_bw == exp_bw) && (bus.in_row == cur_row);

  // Bit-weight pass bw carries weight 4^bw
  assign shamt = {bus.in_bw, 1'b0};

  for (genvar g = 0; g < N; g++) begin : g_col
    logic [ACC_WIDTH-1:0]    lo;
    logic [ACC_WIDTH-1:0]    hi;
    logic [ACC_WIDTH:0]      fuse;
    logic [RESULT_WIDTH-1:0] fuse_ext;

    assign lo = bus.pe_result[2*ACC_WIDTH*g +: ACC_WIDTH];
    assign hi = bus.pe_result[2*ACC_WIDTH*g + ACC_WIDTH +: ACC_WIDTH];

    // One extra bit makes the lane sum exact; two's complement add works on the raw bits
    assign fuse     = {lo[ACC_WIDTH-1], lo} + {hi[ACC_WIDTH-1], hi};
    assign fuse_ext = {{EXT_W{fuse[ACC_WIDTH]}}, fuse};

    // Shift may push bits out of the top: wrap modulo 2^RESULT_WIDTH, no saturation
    assign term[g] = fuse_ext << shamt;
    assign sum[g]  = acc[g] + term[g];
  end

  // Row-assembly FSM plus output register; all outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      exp_bw      <= 2'd0;
      cur_row     <= '0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      for (int n = 0; n < N; n++) begin
        acc[n] <= '0;
      end
    end else begin
      // Consumer took the row; a completing row below overrides this
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (accept) begin
        if (hit) begin
          for (int n = 0; n < N; n++) begin
            acc[n] <= sum[n];
          end
          if (bus.in_bw == 2'd3) begin
            for (int n = 0; n < N; n++) begin
              out_data_q[RESULT_WIDTH*n +: RESULT_WIDTH] <= sum[n];
            end
            out_row_q   <= cur_row;
            out_valid_q <= 1'b1;
            state       <= IDLE;
            exp_bw      <= 2'd0;
          end else begin
            exp_bw <= exp_bw + 2'd1;
          end
        end else if (bus.in_bw == 2'd0) begin
          // Fresh row; overwriting acc avoids a clear cycle. Any open row is abandoned.
          for (int n = 0; n < N; n++) begin
            acc[n] <= term[n];
          end
          cur_row <= bus.in_row;
          state   <= ACC;
          exp_bw  <= 2'd1;
          if (state == ACC) begin
            seq_err_q <= 1'b1;
          end
        end else begin
          // Out-of-order pass with no row it can belong to: drop it and the open row
          state     <= IDLE;
          exp_bw    <= 2'd0;
          seq_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_valid = out_valid_q;
  assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_opt4c_column_result_collector.sv
// Directed bench for the column result collector: row sums, wrap, backpressure, sequence errors, reset.
// Inputs driven 1 time unit after the rising edge, outputs sampled at that same point.
// out_ready toggled explicitly to exercise the stall path.
module tb_opt4c_column_result_collector;

  localparam int N  = 32;
  localparam int AW = 26;
  localparam int RW = 32;
  localparam int M  = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  opt4c_column_result_collector_if #(.N(N), .ACC_WIDTH(AW), .RESULT_WIDTH(RW), .M(M)) bus ();

  opt4c_column_result_collector #(.N(N), .ACC_WIDTH(AW), .RESULT_WIDTH(RW), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int elem(input int n);
    return bus.out_data[RW*n +: RW];
  endfunction

  // Number of output elements that differ from v
  function automatic int count_ne(input int v);
    int c = 0;
    for (int n = 0; n < N; n++) begin
      if (elem(n) != v) c++;
    end
    return c;
  endfunction

  task automatic set_col(input int n, input int lo, input int hi);
    bus.pe_result[2*AW*n +: AW]      = AW'(lo);
    bus.pe_result[2*AW*n + AW +: AW] = AW'(hi);
  endtask

  task automatic set_all(input int lo, input int hi);
    for (int n = 0; n < N; n++) set_col(n, lo, hi);
  endtask

  // One beat presented for exactly one clock edge
  task automatic beat(input int bw, input int row);
    bus.in_valid = 1'b1;
    bus.in_bw    = 2'(bw);
    bus.in_row   = 5'(row);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic full_row(input int row);
    for (int bw = 0; bw < 4; bw++) beat(bw, row);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.pe_result = '0;
    bus.in_valid  = 1'b0;
    bus.in_bw     = 2'd0;
    bus.in_row    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_seq_err", bus.seq_err, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_row", bus.out_row, 0);
    chk("rst_out_data_any", |bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic row: fuse 3, weights 1+4+16+64 -> 255
    set_all(5, -2);
    beat(0, 5);
    beat(1, 5);
    beat(2, 5);
    chk("basic_no_early_valid", bus.out_valid, 0);
    beat(3, 5);
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_row", bus.out_row, 5);
    chk("basic_elems_ne_255", count_ne(255), 0);
    chk("basic_elem31", elem(31), 255);
    @(posedge clk);
    #1;
    chk("basic_valid_cleared", bus.out_valid, 0);

    // Negative value on bw3 only: -100 * 64
    set_all(0, 0);
    beat(0, 7);
    beat(1, 7);
    beat(2, 7);
    set_col(0, -100, 0);
    beat(3, 7);
    chk("neg_elem0", elem(0), -6400);
    chk("neg_elem1", elem(1), 0);
    chk("neg_elem31", elem(31), 0);
    chk("neg_row", bus.out_row, 7);

    // Wrap: fuse = -2^26, shifted = -2^32 == 0 mod 2^32
    set_all(0, 0);
    beat(0, 9);
    beat(1, 9);
    beat(2, 9);
    set_col(1, -33554432, -33554432);
    beat(3, 9);
    chk("wrap_valid", bus.out_valid, 1);
    chk("wrap_elem1", elem(1), 0);
    chk("wrap_elem0", elem(0), 0);
    chk("wrap_seq_err", bus.seq_err, 0);

    // Back-to-back rows with no bubble: 85 then 170
    set_all(1, 0);
    full_row(12);
    chk("b2b_first_valid", bus.out_valid, 1);
    chk("b2b_first_row", bus.out_row, 12);
    chk("b2b_first_elems", count_ne(85), 0);
    set_all(2, 0);
    beat(0, 13);
    chk("b2b_first_taken", bus.out_valid, 0);
    beat(1, 13);
    beat(2, 13);
    beat(3, 13);
    chk("b2b_second_row", bus.out_row, 13);
    chk("b2b_second_elems", count_ne(170), 0);

    // Backpressure: row A (fuse 2 -> 170) held, row B (fuse 7 -> 595) waits
    set_all(1, 1);
    beat(0, 10);
    beat(1, 10);
    beat(2, 10);
    bus.out_ready = 1'b0;
    beat(3, 10);
    chk("bp_a_valid", bus.out_valid, 1);
    chk("bp_in_ready_low", bus.in_ready, 0);
    set_all(3, 4);
    bus.in_valid = 1'b1;
    bus.in_bw    = 2'd0;
    bus.in_row   = 5'd11;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_stall_in_ready", bus.in_ready, 0);
    chk("bp_stall_valid", bus.out_valid, 1);
    chk("bp_stall_row", bus.out_row, 10);
    chk("bp_stall_elems", count_ne(170), 0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    #1;
    chk("bp_a_taken", bus.out_valid, 0);
    chk("bp_in_ready_back", bus.in_ready, 1);
    beat(1, 11);
    beat(2, 11);
    beat(3, 11);
    chk("bp_b_valid", bus.out_valid, 1);
    chk("bp_b_row", bus.out_row, 11);
    chk("bp_b_elems", count_ne(595), 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_b_taken", bus.out_valid, 0);

    // Sequence error: 0,1,3 for row 2, then a clean row 3 (fuse 2 -> 170)
    set_all(1, 0);
    beat(0, 2);
    beat(1, 2);
    chk("seq_clean_before", bus.seq_err, 0);
    beat(3, 2);
    chk("seq_err_set", bus.seq_err, 1);
    chk("seq_no_row2", bus.out_valid, 0);
    set_all(0, 2);
    full_row(3);
    chk("seq_row3_valid", bus.out_valid, 1);
    chk("seq_row3_row", bus.out_row, 3);
    chk("seq_row3_elems", count_ne(170), 0);
    chk("seq_err_sticky", bus.seq_err, 1);

    // Reset mid-row, after the bw2 beat
    set_all(1, 2);
    beat(0, 4);
    beat(1, 4);
    beat(2, 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_seq_err", bus.seq_err, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // The abandoned row must not complete from a lone bw3 beat
    beat(3, 4);
    chk("post_rst_no_stale_row", bus.out_valid, 0);
    chk("post_rst_orphan_err", bus.seq_err, 1);
    set_all(-7, 3);
    full_row(6);
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_row", bus.out_row, 6);
    chk("post_rst_elems", count_ne(-340), 0);
    chk("post_rst_elem0", elem(0), -340);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
